param_memory: RTL
=================

# param_memory

Parametrised single-port synchronous data memory, successor to the fixed 16-bit `Memory` block of the CPU datapath. Adds configurable width and depth, a registered read with a valid strobe, and a hardware clear sweep that zeroes the array one word per cycle. An out-of-range address check is also added. It sits between the datapath's load/store stage and nothing else, and is the single data-memory instance of the processor.

## Interface
Parameters:
- `DATA_WIDTH`, 16, word width in bits (≥1)
- `ADDR_WIDTH`, 16, address bus width
- `DEPTH`, 256, number of words implemented; must satisfy 2 ≤ DEPTH ≤ 2^ADDR_WIDTH

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `address`  in  ADDR_WIDTH  word address for read/write
- `data_to_write`  in  DATA_WIDTH  write data
- `writeif`  in  1  write request, sampled on rising edge
- `readif`  in  1  read request, sampled on rising edge
- `clear`  in  1  start clear sweep, sampled on rising edge
- `output_data`  out  DATA_WIDTH  registered read data
- `read_valid`  out  1  one-cycle pulse: `output_data` updated this cycle
- `busy`  out  1  high while clear sweep runs
- `addr_error`  out  1  one-cycle pulse: accepted request had address ≥ DEPTH
- `req_dropped`  out  1  one-cycle pulse: read/write request arrived while busy

## Operation
- FSM states: IDLE, CLEAR.
- IDLE:
  - `writeif`=1, address < DEPTH: mem[address] ← data_to_write.
  - `readif`=1, address < DEPTH: `output_data` ← mem[address], `read_valid`=1 next cycle.
  - `readif` with address ≥ DEPTH: `output_data` ← 0, `read_valid`=1, `addr_error`=1.
  - `writeif` with address ≥ DEPTH: array unchanged, `addr_error`=1.
  - `writeif` and `readif` together, same address: read returns the old word (read-before-write). The write still happens.
  - `clear`=1: go to CLEAR with the sweep pointer at 0. Any read/write sampled in the same cycle is still serviced.
- CLEAR:
  - Each cycle: mem[ptr] ← 0, then ptr ← ptr+1.
  - When ptr = DEPTH−1 is written, return to IDLE.
  - `readif`/`writeif` are ignored and pulse `req_dropped`.
  - `clear` is ignored; the sweep does not restart.
- `output_data` holds its last value when no read completes.
- The sweep pointer is $clog2(DEPTH) bits wide and never wraps past DEPTH−1.
- Address comparison is unsigned and uses the full ADDR_WIDTH. Upper bits are not truncated.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM enters CLEAR with ptr=0.
  - `busy`=1, `output_data`=0, `read_valid`=0, `addr_error`=0, `req_dropped`=0.
  - Array contents are defined only after the post-reset sweep.
- Reset during a sweep restarts the sweep from 0.
- Read latency: 1 cycle. A request at edge N gives `output_data` and `read_valid` valid after edge N.
- Write latency: data is visible to a read sampled at edge N+1.
- `busy` is registered:
  - rises the cycle after `clear` is accepted;
  - stays high exactly DEPTH cycles;
  - falls in the same cycle the FSM returns to IDLE.
- A request at the first edge with `busy`=0 is serviced.
- `addr_error` and `req_dropped` are registered pulses, one cycle after the offending edge.

## Structure
- Shared package `mem_pkg`: FSM state enum (IDLE, CLEAR) and a `ptr_width(DEPTH)` constant function.
- Sub-module `mem_clear_sweeper`: owns the FSM, pointer and `busy`. Outputs a clear-write enable and clear address.
- Top level owns the array, the write mux (sweeper vs. port), the read register and the error flags.
- Target size: ~200 lines of RTL.

## Test plan
- Reset, then wait: `busy`=1 for 256 cycles (DEPTH=256). Then reading every address returns 0.
- Write 0x0003 @1, then read @1: `output_data`=0x0003 with `read_valid` one cycle later. Read @3 returns 0.
- Preload 0x00AA @5, then in the same cycle write 0x0006 @5 and read @5: output 0x00AA. The next read of @5 returns 0x0006.
- Read @0x0100 and write @0x0200 (DEPTH=256): each pulses `addr_error`. Read data is 0 and the array is unchanged.
- Pulse `clear` after writes, then issue a read mid-sweep: `req_dropped` pulses and `read_valid` stays 0. After `busy` falls, all words are 0.
- Assert `rst_n`=0 asynchronously mid-read: outputs go to reset values immediately and the sweep restarts. Repeat with DATA_WIDTH=32, DEPTH=16: `busy` lasts 16 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_pkg : shared types and helpers for param_memory        rev 1.0
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } sweep_state_t;

  // At least one bit so a two-word memory still has a usable pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_clear_sweeper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_clear_sweeper : IDLE/CLEAR FSM that zeroes the array one word per cycle
// rev 1.0
// ---------------------------------------------------------------------------
module mem_clear_sweeper
  import mem_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int PTR_WIDTH = ptr_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  output logic                 busy,
  output logic                 clear_we,
  output logic [PTR_WIDTH-1:0] clear_addr
);

  localparam logic [PTR_WIDTH-1:0] c_last = PTR_WIDTH'(DEPTH - 1);

  sweep_state_t         r_state;
  logic [PTR_WIDTH-1:0] r_ptr;
  logic                 r_busy;

  // Reset lands in CLEAR so the array is defined once the first sweep ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_ptr == c_last) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ptr   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign clear_we   = (r_state == ST_CLEAR);
  assign clear_addr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/param_memory.sv
`default_nettype none
// ---------------------------------------------------------------------------
// param_memory : single-port data memory, registered read, hardware clear
// rev 1.0
// ---------------------------------------------------------------------------
module param_memory
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_to_write,
  input  logic                  writeif,
  input  logic                  readif,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  addr_error,
  output logic                  req_dropped
);

  localparam int                  c_ptr_w = ptr_width(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic               w_busy;
  logic               w_clear_we;
  logic [c_ptr_w-1:0] w_clear_addr;
  logic               w_in_range;
  logic               w_idle;
  logic               w_port_we;
  logic [c_ptr_w-1:0] w_idx;

  mem_clear_sweeper #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (c_ptr_w)
  ) u_sweeper (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .busy       (w_busy),
    .clear_we   (w_clear_we),
    .clear_addr (w_clear_addr)
  );

  // Compare the full address bus so aliased upper bits are rejected.
  assign w_in_range = ({1'b0, address} < c_depth);
  assign w_idx      = address[c_ptr_w-1:0];
  assign w_idle     = !w_busy;
  assign w_port_we  = w_idle && writeif && w_in_range;

  always_ff @(posedge clk) begin
    if (w_clear_we) begin
      r_mem[w_clear_addr] <= '0;
    end else if (w_port_we) begin
      r_mem[w_idx] <= data_to_write;
    end
  end

  // Same-edge read sees the pre-write word, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_data <= '0;
      read_valid  <= 1'b0;
      addr_error  <= 1'b0;
      req_dropped <= 1'b0;
    end else if (w_idle) begin
      read_valid  <= readif;
      addr_error  <= (readif || writeif) && !w_in_range;
      req_dropped <= 1'b0;
      if (readif) begin
        output_data <= w_in_range ? r_mem[w_idx] : '0;
      end
    end else begin
      read_valid  <= 1'b0;
      addr_error  <= 1'b0;
      req_dropped <= readif || writeif;
    end
  end

  assign busy = w_busy;

endmodule
`default_nettype wire
